// File: rtl/memshare_vn_iblut_mc.sv
// memshare_vn_iblut_mc: ping-pong LUT shared by CH_NUM mapping channels, reloaded page-wise from a stream
module memshare_vn_iblut_mc #(
  parameter int ADDR_WIDTH    = 6,
  parameter int VN_LOAD_CYCLE = 64,
  parameter int MSG_WIDTH     = 4,
  parameter int CH_NUM        = 4
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic [CH_NUM-1:0]              map_en_i,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   map_addr_i,
  output logic [CH_NUM*MSG_WIDTH-1:0]    msgOut_o,
  output logic [CH_NUM-1:0]              msgOut_vld_o,
  input  logic                           remap_start_i,
  input  logic [MSG_WIDTH-1:0]           remap_dataIn_i,
  input  logic                           remap_vld_i,
  output logic                           remap_rdy_o,
  output logic                           remap_busy_o,
  output logic                           remap_done_o,
  output logic                           active_page_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SWAP} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VN_LOAD_CYCLE - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(VN_LOAD_CYCLE);
  state_t                state;
  logic [1:0]            rs;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] wcnt;
  logic                  wr;
  logic [MSG_WIDTH-1:0]  pg0 [VN_LOAD_CYCLE];
  logic [MSG_WIDTH-1:0]  pg1 [VN_LOAD_CYCLE];
  // reset asserts immediately, releases two edges after rstn rises
  always_ff @(posedge sys_clk or negedge rstn)
    if (!rstn) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];
  assign wr = remap_vld_i & remap_rdy_o;
  always_ff @(posedge sys_clk)
    if (wr) begin
      if (active_page_o) pg0[wcnt] <= remap_dataIn_i;
      else pg1[wcnt] <= remap_dataIn_i;
    end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      wcnt          <= '0;
      active_page_o <= 1'b0;
      remap_rdy_o   <= 1'b0;
      remap_busy_o  <= 1'b0;
      remap_done_o  <= 1'b0;
    end else begin
      remap_done_o <= 1'b0;
      case (state)
        IDLE: if (remap_start_i) begin
          state        <= LOAD;
          wcnt         <= '0;
          remap_rdy_o  <= 1'b1;
          remap_busy_o <= 1'b1;
        end
        LOAD: if (wr) begin
          if (wcnt == LAST) begin
            state       <= SWAP;
            remap_rdy_o <= 1'b0;
          end else wcnt <= wcnt + 1'b1;
        end
        SWAP: begin
          state         <= IDLE;
          active_page_o <= ~active_page_o;
          remap_done_o  <= 1'b1;
          remap_busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [ADDR_WIDTH-1:0] a;
    logic [MSG_WIDTH-1:0]  msg_q;
    logic                  vld_q;
    logic                  in_rng;
    assign a      = map_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_rng = {1'b0, a} < DEPTH;
    always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
        msg_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= map_en_i[k];
        if (map_en_i[k]) msg_q <= !in_rng ? '0 : active_page_o ? pg1[a] : pg0[a];
      end
    assign msgOut_o[k*MSG_WIDTH +: MSG_WIDTH] = msg_q;
    assign msgOut_vld_o[k] = vld_q;
  end
endmodule

// File: doc/memshare_vn_iblut_mc.md
MEMSHARE_VN_IBLUT_MC -- requirements
Module: memshare_vn_iblut_mc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning the width of each channel's LUT address.
REQ-002 SHALL have parameter VN_LOAD_CYCLE, default 64, meaning the number of LUT entries per page; VN_LOAD_CYCLE <= 2^ADDR_WIDTH.
REQ-003 SHALL have parameter MSG_WIDTH, default 4, meaning the width of each LUT entry and message.
REQ-004 SHALL have parameter CH_NUM, default 4, meaning the number of parallel mapping channels sharing one LUT.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock for all logic; reads and writes use the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port map_en_i, input, CH_NUM bits: per-channel mapping request.
REQ-008 SHALL have port map_addr_i, input, CH_NUM*ADDR_WIDTH bits: per-channel address; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port msgOut_o, output, CH_NUM*MSG_WIDTH bits: registered per-channel mapping result.
REQ-010 SHALL have port msgOut_vld_o, output, CH_NUM bits: per-channel result valid.
REQ-011 SHALL have port remap_start_i, input, 1 bit: starts a page reload.
REQ-012 SHALL have ports remap_dataIn_i (input, MSG_WIDTH bits), remap_vld_i (input, 1 bit) and remap_rdy_o (output, 1 bit): the remap data stream handshake.
REQ-013 SHALL have port remap_busy_o, output, 1 bit: high while the FSM is not in IDLE.
REQ-014 SHALL have port remap_done_o, output, 1 bit: one-cycle pulse after a page swap.
REQ-015 SHALL have port active_page_o, output, 1 bit: index of the page currently serving mapping reads.

Function
REQ-016 SHALL hold two pages (ping-pong), each VN_LOAD_CYCLE x MSG_WIDTH; mapping reads always use the active page and remap writes always use the shadow page (~active_page_o).
REQ-017 SHALL give each channel 1-cycle latency: with map_en_i[k]=1 at edge N, msgOut_o[k] = active_page[addr_k] and msgOut_vld_o[k] = 1 after edge N; with map_en_i[k]=0, vld=0 and msgOut_o[k] holds its last value.
REQ-018 SHALL return 0, with vld=1, for a channel address >= VN_LOAD_CYCLE.
REQ-019 SHALL serve all CH_NUM channels in the same cycle, including identical addresses, with no stall.
REQ-020 SHALL implement FSM states IDLE, LOAD and SWAP; reset state is IDLE.
REQ-021 IDLE: remap_rdy_o=0; on remap_start_i=1 SHALL go to LOAD and clear the write counter wcnt to 0.
REQ-022 LOAD: remap_rdy_o=1; each cycle with remap_vld_i & remap_rdy_o SHALL write remap_dataIn_i to shadow[wcnt] and increment wcnt; cycles with vld=0 SHALL insert no write and change no state.
REQ-023 LOAD SHALL go to SWAP on the beat that writes wcnt == VN_LOAD_CYCLE-1; remap_rdy_o SHALL be 0 in the following cycle.
REQ-024 SWAP SHALL last one cycle: active_page_o toggles at the end of the SWAP cycle, remap_done_o=1 in the next cycle, then the FSM returns to IDLE.
REQ-025 A mapping read issued during the SWAP cycle SHALL use the old page; reads from the next cycle on SHALL use the new page.
REQ-026 SHALL ignore remap_start_i outside IDLE, and a start asserted in the remap_done_o cycle SHALL be accepted, since the FSM is then in IDLE.
REQ-027 Mapping channels SHALL stay fully operational through LOAD and SWAP with no wait states.

Reset
REQ-028 On rstn=0 SHALL asynchronously set: FSM=IDLE, wcnt=0, active_page_o=0, msgOut_o=0, msgOut_vld_o=0, remap_rdy_o=0, remap_busy_o=0, remap_done_o=0.
REQ-029 LUT page contents SHALL be unaffected by reset (LUTRAM) and are undefined until loaded; a reset during LOAD SHALL abandon the load with no swap.
REQ-030 Reset deassertion SHALL be synchronised to sys_clk so that the first active edge is glitch-free.

Verification
REQ-031 Load page1 with entry i = i mod 16 (64 beats, vld always 1), then ch0..3 addresses 0,5,17,63 -> msgOut = 0,5,1,15 one cycle later, active_page_o=1, one done pulse.
REQ-032 Load with vld toggled every other cycle -> exactly 64 writes, done after 128+2 cycles, contents match the data sent.
REQ-033 All channels read address 10 continuously during load and swap -> old value through the SWAP cycle, new value from the next cycle, vld never drops.
REQ-034 remap_start_i pulsed mid-LOAD -> ignored, wcnt continues, a single swap occurs.
REQ-035 rstn=0 after 30 beats of a load -> all outputs 0, active_page_o=0, no done pulse; a new full load then completes normally.
REQ-036 ADDR_WIDTH=6 with VN_LOAD_CYCLE=40, address 45 -> msgOut=0 with vld=1.
